// File: rtl/mod_exp_ctrl_pkg.sv
// rtl/mod_exp_ctrl_pkg.sv - shared widths and FSM state encoding for the modexp controller
package mod_exp_ctrl_pkg;

  localparam int BIT_LEN_DEF = 64;
  localparam int EXP_LEN_DEF = 64;
  localparam int CNT_W_DEF   = 7;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_SCAN     = 4'd1,
    S_SQ_REQ   = 4'd2,
    S_SQ_WAIT  = 4'd3,
    S_MUL_REQ  = 4'd4,
    S_MUL_WAIT = 4'd5,
    S_OUT_REQ  = 4'd6,
    S_OUT_WAIT = 4'd7,
    S_FIN      = 4'd8
  } state_e;

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// rtl/mod_exp_ctrl_if.sv - request/response port between the controller and mon_pro
interface mod_exp_ctrl_if #(
  parameter int BIT_LEN = 64
);
  logic               mp_start;
  logic [BIT_LEN-1:0] mp_a;
  logic [BIT_LEN-1:0] mp_b;
  logic [BIT_LEN-1:0] mp_m;
  logic               mp_done;
  logic [BIT_LEN-1:0] mp_p;

  modport master (output mp_start, mp_a, mp_b, mp_m, input mp_done, mp_p);
  modport slave  (input mp_start, mp_a, mp_b, mp_m, output mp_done, mp_p);
endinterface

// File: rtl/mod_exp_ctrl_exp_bit_scan.sv
// rtl/mod_exp_ctrl_exp_bit_scan.sv - exponent shift register and remaining-bit counter
module exp_bit_scan
  import mod_exp_ctrl_pkg::*;
#(
  parameter int EXP_LEN = EXP_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               shift,
  input  logic [EXP_LEN-1:0] load_val,
  output logic               msb,
  output logic               zero,
  output logic               last
);
  logic [EXP_LEN-1:0] e_sh_q, e_sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    e_sh_d = e_sh_q;
    cnt_d  = cnt_q;
    if (load) begin
      e_sh_d = load_val;
      cnt_d  = CNT_W'(EXP_LEN);
    end else if (shift) begin
      e_sh_d = {e_sh_q[EXP_LEN-2:0], 1'b0};
      cnt_d  = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_sh_q <= '0;
      cnt_q  <= '0;
    end else begin
      e_sh_q <= e_sh_d;
      cnt_q  <= cnt_d;
    end
  end

  assign msb  = e_sh_q[EXP_LEN-1];
  assign zero = (cnt_q == '0);
  // last: the pending shift consumes the final exponent bit
  assign last = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/mod_exp_ctrl.sv
// rtl/mod_exp_ctrl.sv - left-to-right binary modular exponentiation sequencer for mon_pro
module mod_exp_ctrl
  import mod_exp_ctrl_pkg::*;
#(
  parameter int BIT_LEN = BIT_LEN_DEF,
  parameter int EXP_LEN = EXP_LEN_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BIT_LEN-1:0] x_bar,
  input  logic [BIT_LEN-1:0] one_bar,
  input  logic [EXP_LEN-1:0] exponent,
  input  logic [BIT_LEN-1:0] modulus,
  output logic               busy,
  output logic               done,
  output logic [BIT_LEN-1:0] result,
  mod_exp_ctrl_if.master     mp
);
  state_e             state_q, state_d;
  logic [BIT_LEN-1:0] acc_q, acc_d, x_bar_q, x_bar_d, mod_q, mod_d;
  logic [BIT_LEN-1:0] result_q, result_d, mp_a_q, mp_a_d, mp_b_q, mp_b_d;
  logic               busy_q, busy_d, done_q, done_d, mp_start_q, mp_start_d;
  logic               scan_load, scan_shift, scan_msb, scan_zero, scan_last;

  exp_bit_scan #(.EXP_LEN(EXP_LEN), .CNT_W(CNT_W)) u_scan (
    .clk(clk), .rst(rst), .load(scan_load), .shift(scan_shift), .load_val(exponent),
    .msb(scan_msb), .zero(scan_zero), .last(scan_last)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    x_bar_d    = x_bar_q;
    mod_d      = mod_q;
    result_d   = result_q;
    mp_a_d     = mp_a_q;
    mp_b_d     = mp_b_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mp_start_d = 1'b0;
    scan_load  = 1'b0;
    scan_shift = 1'b0;
    case (state_q)
      S_IDLE: if (start) begin
        x_bar_d   = x_bar;
        mod_d     = modulus;
        acc_d     = one_bar;
        scan_load = 1'b1;
        busy_d    = 1'b1;
        state_d   = S_SCAN;
      end
      S_SCAN: begin
        if (scan_zero)     state_d = S_OUT_REQ;
        else if (scan_msb) state_d = S_SQ_REQ;
        else               scan_shift = 1'b1;
      end
      S_SQ_REQ: begin
        mp_a_d     = acc_q;
        mp_b_d     = acc_q;
        mp_start_d = 1'b1;
        state_d    = S_SQ_WAIT;
      end
      // A set bit stays at the MSB until its multiply finishes
      S_SQ_WAIT: if (mp.mp_done) begin
        acc_d = mp.mp_p;
        if (scan_msb) begin
          state_d = S_MUL_REQ;
        end else begin
          scan_shift = 1'b1;
          state_d    = scan_last ? S_OUT_REQ : S_SQ_REQ;
        end
      end
      S_MUL_REQ: begin
        mp_a_d     = acc_q;
        mp_b_d     = x_bar_q;
        mp_start_d = 1'b1;
        state_d    = S_MUL_WAIT;
      end
      S_MUL_WAIT: if (mp.mp_done) begin
        acc_d      = mp.mp_p;
        scan_shift = 1'b1;
        state_d    = scan_last ? S_OUT_REQ : S_SQ_REQ;
      end
      S_OUT_REQ: begin
        mp_a_d     = acc_q;
        mp_b_d     = BIT_LEN'(1);
        mp_start_d = 1'b1;
        state_d    = S_OUT_WAIT;
      end
      S_OUT_WAIT: if (mp.mp_done) begin
        result_d = mp.mp_p;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      x_bar_q    <= '0;
      mod_q      <= '0;
      result_q   <= '0;
      mp_a_q     <= '0;
      mp_b_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mp_start_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      x_bar_q    <= x_bar_d;
      mod_q      <= mod_d;
      result_q   <= result_d;
      mp_a_q     <= mp_a_d;
      mp_b_q     <= mp_b_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mp_start_q <= mp_start_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign mp.mp_start = mp_start_q;
  assign mp.mp_a     = mp_a_q;
  assign mp.mp_b     = mp_b_q;
  assign mp.mp_m     = mod_q;
endmodule
